// File: rtl/hwpe_dma_loader_pkg.sv
// -----------------------------------------------------------------------------
// hwpe_dma_loader_pkg
// Shared definitions for the hwpe load sequencer:
//   - loader FSM state encoding (IDLE=0, REQ=1, DRAIN=2, DONE=3)
//   - SEG_IDLE, the segment code meaning "no active segment"
//   - hwpe memory map values (HWPE_ADDR_WIDTH, FMEM_ADDR2_START,
//     KMEM_ADDR_START). These come from hwpe_define.vh when it is compiled
//     ahead of this file; the fallbacks below only fill in what is missing.
//   - next_nz_seg(): finds the next segment with a nonzero length
// -----------------------------------------------------------------------------
`ifndef HWPE_ADDR_WIDTH
`define HWPE_ADDR_WIDTH 16
`endif
`ifndef FMEM_ADDR2_START
`define FMEM_ADDR2_START 16'h4000
`endif
`ifndef KMEM_ADDR_START
`define KMEM_ADDR_START 16'h8000
`endif

package hwpe_dma_loader_pkg;

   typedef enum logic [1:0] {
      LD_IDLE  = 2'd0,
      LD_REQ   = 2'd1,
      LD_DRAIN = 2'd2,
      LD_DONE  = 2'd3
   } ld_state_e;

   localparam logic [1:0] SEG_IDLE = 2'd3;

   localparam int          LD_HWPE_AW    = `HWPE_ADDR_WIDTH;
   localparam int unsigned LD_FMEM2_BASE = `FMEM_ADDR2_START;
   localparam int unsigned LD_KMEM_BASE  = `KMEM_ADDR_START;

   // Lowest segment index >= from whose length is nonzero; SEG_IDLE if none.
   function automatic logic [1:0] next_nz_seg(input logic [2:0] nz, input logic [1:0] from);
      logic [1:0] r;
      r = SEG_IDLE;
      for (int i = 2; i >= 0; i--) begin
         if ((i >= int'(from)) && nz[i]) r = 2'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/hwpe_dma_loader_seg.sv
// -----------------------------------------------------------------------------
// hwpe_loader_seg_cnt
// Segment index + word counter that walks seg0 -> seg1 -> seg2, skipping
// zero-length segments. Used once for the request side and once for the
// write side of the loader.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   load              jump to the first nonzero segment, word index 0
//   step              one word of the current segment consumed
//   len0/len1/len2    segment lengths in words (must be valid on load too)
//   seg               current segment (SEG_IDLE once all words consumed)
//   idx               word index within the current segment
//   fin               this step consumes the very last word of the sequence
// -----------------------------------------------------------------------------
module hwpe_loader_seg_cnt
   import hwpe_dma_loader_pkg::*;
#(
   parameter int LEN_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [LEN_W-1:0] len0,
   input  logic [LEN_W-1:0] len1,
   input  logic [LEN_W-1:0] len2,
   output logic [1:0]       seg,
   output logic [LEN_W-1:0] idx,
   output logic             fin
);

   logic [2:0]       nz;
   logic [LEN_W-1:0] cur_len;
   logic [1:0]       nxt;
   logic             last;

   always_comb begin
      nz = {len2 != '0, len1 != '0, len0 != '0};
      case (seg)
         2'd0:    cur_len = len0;
         2'd1:    cur_len = len1;
         2'd2:    cur_len = len2;
         default: cur_len = '0;
      endcase
      last = (seg != SEG_IDLE) && (idx == cur_len - LEN_W'(1));
      nxt  = (seg == SEG_IDLE) ? SEG_IDLE : next_nz_seg(nz, seg + 2'd1);
      fin  = last && (nxt == SEG_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_IDLE;
         idx <= '0;
      end else if (load) begin
         seg <= next_nz_seg(nz, 2'd0);
         idx <= '0;
      end else if (step && (seg != SEG_IDLE)) begin
         if (last) begin
            seg <= nxt;
            idx <= '0;
         end else begin
            idx <= idx + LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/hwpe_dma_loader.sv
// -----------------------------------------------------------------------------
// hwpe_dma_loader
// Load sequencer for the hwpe SRAMs: fetches 64-bit words from a source read
// port and writes them through the hwpe DMA write port in three segments
// (seg0 fmap bank 1 at cfg_dst0, seg1 fmap bank 2, seg2 kernel memory).
// Optional build macro: HWPE_LOADER_CKSUM_EN adds a running XOR checksum of
// all written data (output cksum), cleared on start.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   start                        one-cycle pulse, samples cfg_* when idle
//   cfg_src0..2, cfg_dst0        source byte bases, seg0 destination base
//   cfg_len0..2                  segment lengths in words (0 = skip)
//   rd_req_valid/ready/addr      source read request channel
//   rd_rsp_valid/data            in-order read responses (no back-pressure)
//   dma_wen/wa/wd                hwpe write port
//   busy, done, seg_id           status (seg_id = write-side segment, 3 idle)
// -----------------------------------------------------------------------------
module hwpe_dma_loader
   import hwpe_dma_loader_pkg::*;
#(
   parameter int ADDR_W    = LD_HWPE_AW,
   parameter int SRC_AW    = 32,
   parameter int LEN_W     = 16,
   parameter int MAX_OUTST = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [SRC_AW-1:0] cfg_src0,
   input  logic [SRC_AW-1:0] cfg_src1,
   input  logic [SRC_AW-1:0] cfg_src2,
   input  logic [ADDR_W-1:0] cfg_dst0,
   input  logic [LEN_W-1:0]  cfg_len0,
   input  logic [LEN_W-1:0]  cfg_len1,
   input  logic [LEN_W-1:0]  cfg_len2,
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [SRC_AW-1:0] rd_req_addr,
   input  logic              rd_rsp_valid,
   input  logic [63:0]       rd_rsp_data,
   output logic              dma_wen,
   output logic [ADDR_W-1:0] dma_wa,
   output logic [63:0]       dma_wd,
   output logic              busy,
   output logic              done,
   output logic [1:0]        seg_id
`ifdef HWPE_LOADER_CKSUM_EN
  ,output logic [63:0]       cksum
`endif
);

   localparam int OUTST_W = $clog2(MAX_OUTST + 1);

   ld_state_e         state_q, state_d;
   logic              start_acc, all_zero, accept, rsp_ok, last_wr_q;
   logic [OUTST_W-1:0] outst_q;

   logic [SRC_AW-1:0] src0_q, src1_q, src2_q, rq_base;
   logic [ADDR_W-1:0] dst0_q, wr_base;
   logic [LEN_W-1:0]  len0_q, len1_q, len2_q, len0_mx, len1_mx, len2_mx;
   logic [1:0]        rq_seg, wr_seg;
   logic [LEN_W-1:0]  rq_idx, wr_idx;
   logic              rq_fin, wr_fin;

   assign start_acc = start && (state_q == LD_IDLE);
   assign all_zero  = (cfg_len0 == '0) && (cfg_len1 == '0) && (cfg_len2 == '0);

   // Counters load from the raw config on the start edge, latched copy after.
   assign len0_mx = start_acc ? cfg_len0 : len0_q;
   assign len1_mx = start_acc ? cfg_len1 : len1_q;
   assign len2_mx = start_acc ? cfg_len2 : len2_q;

   always_ff @(posedge clk) begin
      if (start_acc) begin
         src0_q <= cfg_src0;
         src1_q <= cfg_src1;
         src2_q <= cfg_src2;
         dst0_q <= cfg_dst0;
         len0_q <= cfg_len0;
         len1_q <= cfg_len1;
         len2_q <= cfg_len2;
      end
   end

   hwpe_loader_seg_cnt #(.LEN_W(LEN_W)) u_rq_cnt (
      .clk(clk), .rst_n(rst_n), .load(start_acc), .step(accept),
      .len0(len0_mx), .len1(len1_mx), .len2(len2_mx),
      .seg(rq_seg), .idx(rq_idx), .fin(rq_fin)
   );

   hwpe_loader_seg_cnt #(.LEN_W(LEN_W)) u_wr_cnt (
      .clk(clk), .rst_n(rst_n), .load(start_acc), .step(rsp_ok),
      .len0(len0_mx), .len1(len1_mx), .len2(len2_mx),
      .seg(wr_seg), .idx(wr_idx), .fin(wr_fin)
   );

   always_comb begin
      case (rq_seg)
         2'd0:    rq_base = src0_q;
         2'd1:    rq_base = src1_q;
         2'd2:    rq_base = src2_q;
         default: rq_base = '0;
      endcase
      case (wr_seg)
         2'd0:    wr_base = dst0_q;
         2'd1:    wr_base = ADDR_W'(LD_FMEM2_BASE);
         2'd2:    wr_base = ADDR_W'(LD_KMEM_BASE);
         default: wr_base = '0;
      endcase
   end

   // Address is derived from the request counter, so it is 0 when idle and
   // cannot move while a request waits for ready.
   assign rd_req_addr  = rq_base + SRC_AW'({rq_idx, 3'b000});
   assign rd_req_valid = (state_q == LD_REQ) && (rq_seg != SEG_IDLE) &&
                         (outst_q < OUTST_W'(MAX_OUTST));
   assign accept       = rd_req_valid && rd_req_ready;
   // Responses with nothing outstanding are strays (e.g. after an abort).
   assign rsp_ok       = rd_rsp_valid && (outst_q != '0);

   always_comb begin
      state_d = state_q;
      case (state_q)
         LD_IDLE:  if (start) state_d = all_zero ? LD_DONE : LD_REQ;
         LD_REQ:   if (accept && rq_fin) state_d = LD_DRAIN;
         LD_DRAIN: if ((outst_q == '0) && last_wr_q) state_d = LD_DONE;
         LD_DONE:  state_d = LD_IDLE;
         default:  state_d = LD_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= LD_IDLE;
         outst_q   <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         seg_id    <= SEG_IDLE;
         last_wr_q <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= (state_q == LD_DONE);
         case ({accept, rsp_ok})
            2'b10:   outst_q <= outst_q + OUTST_W'(1);
            2'b01:   outst_q <= outst_q - OUTST_W'(1);
            default: outst_q <= outst_q;
         endcase
         if (start_acc) busy <= 1'b1;
         else if (state_q == LD_DONE) busy <= 1'b0;
         if (start_acc) last_wr_q <= 1'b0;
         else if (rsp_ok && wr_fin) last_wr_q <= 1'b1;
         if (state_q == LD_DONE) seg_id <= SEG_IDLE;
         else if (start_acc) seg_id <= next_nz_seg({cfg_len2 != '0, cfg_len1 != '0, cfg_len0 != '0}, 2'd0);
         else if (rsp_ok) seg_id <= wr_seg;
      end
   end

   // ---- write stage: response registered into the hwpe write port ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dma_wen <= 1'b0;
         dma_wa  <= '0;
         dma_wd  <= '0;
      end else begin
         dma_wen <= rsp_ok;
         if (rsp_ok) begin
            dma_wa <= wr_base + ADDR_W'({wr_idx, 3'b000});
            dma_wd <= rd_rsp_data;
         end
      end
   end

`ifdef HWPE_LOADER_CKSUM_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cksum <= '0;
      else if (start_acc) cksum <= '0;
      else if (dma_wen) cksum <= cksum ^ dma_wd;
   end
`endif

endmodule

// File: tb/tb_hwpe_dma_loader.sv
module tb_hwpe_dma_loader;
   import hwpe_dma_loader_pkg::*;

   localparam int AW  = LD_HWPE_AW;
   localparam int SAW = 32;
   localparam int LW  = 16;
   localparam int MO  = 4;

   logic           clk, rst_n, start;
   logic [SAW-1:0] cfg_src0, cfg_src1, cfg_src2;
   logic [AW-1:0]  cfg_dst0;
   logic [LW-1:0]  cfg_len0, cfg_len1, cfg_len2;
   logic           rd_req_valid, rd_req_ready;
   logic [SAW-1:0] rd_req_addr;
   logic           rd_rsp_valid;
   logic [63:0]    rd_rsp_data;
   logic           dma_wen;
   logic [AW-1:0]  dma_wa;
   logic [63:0]    dma_wd;
   logic           busy, done;
   logic [1:0]     seg_id;
`ifdef HWPE_LOADER_CKSUM_EN
   logic [63:0]    cksum;
`endif

   hwpe_dma_loader #(.ADDR_W(AW), .SRC_AW(SAW), .LEN_W(LW), .MAX_OUTST(MO)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_src0(cfg_src0), .cfg_src1(cfg_src1), .cfg_src2(cfg_src2),
      .cfg_dst0(cfg_dst0), .cfg_len0(cfg_len0), .cfg_len1(cfg_len1), .cfg_len2(cfg_len2),
      .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr),
      .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
      .dma_wen(dma_wen), .dma_wa(dma_wa), .dma_wd(dma_wd),
      .busy(busy), .done(done), .seg_id(seg_id)
`ifdef HWPE_LOADER_CKSUM_EN
     ,.cksum(cksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [AW-1:0] wa; logic [63:0] wd; logic [1:0] seg; } wr_t;
   typedef struct { logic [SAW-1:0] addr; int due; } pend_t;

   wr_t            exp_wr[$];
   logic [SAW-1:0] exp_req[$];
   pend_t          pend[$];

   int n_chk = 0, n_pass = 0;
   int cyc = 0, lat = 3, ready_mode = 0, stray_left = 0, bench_outst = 0;
   int done_cnt = 0, wr_cnt = 0, done_cyc = 0, start_cyc = 0, log_n = 0;
   logic           prev_stall = 1'b0;
   logic [SAW-1:0] prev_addr = '0;
   logic           start_pend = 1'b0;
   logic [63:0]    model_ck = '0;
   logic [AW-1:0]  log_wa[16];
   logic [1:0]     log_seg[16];

   // Source memory image: every 8-byte source address holds a distinct word.
   function automatic logic [63:0] src_word(input logic [SAW-1:0] a);
      return {a ^ 32'hA5A5_0000, ~a};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
   endtask

   // One clock cycle: compare DUT outputs against the model, then drive inputs.
   task automatic step();
      wr_t   e;
      pend_t p;
      @(negedge clk);
      cyc++;
      if (dma_wen) begin
         wr_cnt++;
         if (exp_wr.size() == 0) chk("unexpected_write", 64'(dma_wen), 64'd0);
         else begin
            e = exp_wr.pop_front();
            chk("wr_addr", 64'(dma_wa), 64'(e.wa));
            chk("wr_data", dma_wd, e.wd);
            chk("wr_seg_id", 64'(seg_id), 64'(e.seg));
            model_ck ^= e.wd;
            if (log_n < 16) begin
               log_wa[log_n] = dma_wa;
               log_seg[log_n] = seg_id;
               log_n++;
            end
         end
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (prev_stall) begin
         chk("req_hold_valid", 64'(rd_req_valid), 64'd1);
         chk("req_hold_addr", 64'(rd_req_addr), 64'(prev_addr));
      end
      if (rst_n && !busy) begin
         chk("idle_seg_id", 64'(seg_id), 64'(SEG_IDLE));
         chk("idle_req_valid", 64'(rd_req_valid), 64'd0);
         chk("idle_wen", 64'(dma_wen), 64'd0);
      end
      rd_req_ready = (ready_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rst_n && rd_req_valid && rd_req_ready) begin
         if (exp_req.size() == 0) chk("unexpected_req", 64'(rd_req_valid), 64'd0);
         else chk("req_addr", 64'(rd_req_addr), 64'(exp_req.pop_front()));
         pend.push_back('{rd_req_addr, cyc + lat});
         bench_outst++;
         chk("outstanding_limit", 64'(bench_outst <= MO), 64'd1);
      end
      prev_stall = rst_n && rd_req_valid && !rd_req_ready;
      prev_addr  = rd_req_addr;
      rd_rsp_valid = 1'b0;
      rd_rsp_data  = '0;
      if (stray_left > 0) begin
         rd_rsp_valid = 1'b1;
         rd_rsp_data  = 64'hDEAD_BEEF_0BAD_F00D;
         stray_left--;
      end else if (pend.size() > 0 && pend[0].due <= cyc) begin
         p = pend.pop_front();
         rd_rsp_valid = 1'b1;
         rd_rsp_data  = src_word(p.addr);
         bench_outst--;
      end
      start = start_pend;
      start_pend = 1'b0;
   endtask

   // Build expected traffic from the segment rules and issue a start pulse.
   task automatic launch(input logic [SAW-1:0] s0, s1, s2, input logic [AW-1:0] d0,
                         input int l0, l1, l2);
      logic [SAW-1:0] src[3];
      logic [AW-1:0]  dst[3];
      int             len[3];
      src = '{s0, s1, s2};
      dst = '{d0, AW'(LD_FMEM2_BASE), AW'(LD_KMEM_BASE)};
      len = '{l0, l1, l2};
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < len[k]; i++) begin
            exp_req.push_back(SAW'(src[k] + SAW'(8 * i)));
            exp_wr.push_back('{AW'(dst[k] + AW'(8 * i)), src_word(SAW'(src[k] + SAW'(8 * i))), 2'(k)});
         end
      cfg_src0 = s0; cfg_src1 = s1; cfg_src2 = s2; cfg_dst0 = d0;
      cfg_len0 = LW'(l0); cfg_len1 = LW'(l1); cfg_len2 = LW'(l2);
      done_cnt = 0; wr_cnt = 0; log_n = 0; model_ck = '0;
      start_pend = 1'b1;
      start_cyc = cyc + 1;
   endtask

   task automatic run(input logic [SAW-1:0] s0, s1, s2, input logic [AW-1:0] d0,
                      input int l0, l1, l2, input int budget, input bit extra_start);
      launch(s0, s1, s2, d0, l0, l1, l2);
      for (int n = 0; n < budget && done_cnt == 0; n++) begin
         step();
         if (extra_start && n == 20) begin
            cfg_len0 = 16'd9; cfg_len1 = 16'd9; cfg_len2 = 16'd9;
            start_pend = 1'b1;
         end
      end
      chk("done_seen", 64'(done_cnt), 64'd1);
      repeat (4) step();
      chk("done_once", 64'(done_cnt), 64'd1);
      chk("writes_left", 64'(exp_wr.size()), 64'd0);
      chk("reqs_left", 64'(exp_req.size()), 64'd0);
      chk("write_count", 64'(wr_cnt), 64'(l0 + l1 + l2));
      chk("busy_after_done", 64'(busy), 64'd0);
`ifdef HWPE_LOADER_CKSUM_EN
      chk("cksum", cksum, model_ck);
`endif
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; rd_req_ready = 1'b0;
      rd_rsp_valid = 1'b0; rd_rsp_data = '0;
      cfg_src0 = '0; cfg_src1 = '0; cfg_src2 = '0; cfg_dst0 = '0;
      cfg_len0 = '0; cfg_len1 = '0; cfg_len2 = '0;
      repeat (3) step();
      chk("rst_req_valid", 64'(rd_req_valid), 64'd0);
      chk("rst_req_addr", 64'(rd_req_addr), 64'd0);
      chk("rst_wen", 64'(dma_wen), 64'd0);
      chk("rst_wa", 64'(dma_wa), 64'd0);
      chk("rst_wd", dma_wd, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_seg_id", 64'(seg_id), 64'd3);
      rst_n = 1'b1;
      repeat (2) step();

      // Full-size load, ready always high, 3-cycle response latency.
      lat = 3; ready_mode = 0;
      run(32'h1000_0000, 32'h2000_0000, 32'h3000_0000, 16'h0000, 130, 130, 1152, 6000, 1'b0);
      chk("big_first_wa", 64'(log_wa[1]), 64'h0008);

      // Zero-length middle segment.
      run(32'h0000_4000, 32'h0000_5000, 32'h0000_6000, 16'h0100, 3, 0, 2, 200, 1'b0);
      chk("skip_wa0", 64'(log_wa[0]), 64'h0100);
      chk("skip_wa2", 64'(log_wa[2]), 64'h0110);
      chk("skip_wa3", 64'(log_wa[3]), 64'h8000);
      chk("skip_wa4", 64'(log_wa[4]), 64'h8008);
      chk("skip_seg2", 64'(log_seg[2]), 64'd0);
      chk("skip_seg3", 64'(log_seg[3]), 64'd2);
      chk("skip_seg4", 64'(log_seg[4]), 64'd2);
      chk("skip_count", 64'(wr_cnt), 64'd5);

      // All lengths zero: done two cycles after start.
      run(32'h0, 32'h0, 32'h0, 16'h0, 0, 0, 0, 20, 1'b0);
      chk("zero_done_latency", 64'(done_cyc - start_cyc), 64'd2);

      // Random ready with address wrap on both sides.
      lat = 2; ready_mode = 1;
      run(32'h0000_7000, 32'hFFFF_FFF8, 32'h0000_9000, 16'hFFF8, 2, 3, 4, 500, 1'b0);
      chk("rand_count", 64'(wr_cnt), 64'd9);
      chk("wrap_wa1", 64'(log_wa[1]), 64'h0000);

      // Second start while busy is ignored.
      run(32'h0001_0000, 32'h0002_0000, 32'h0003_0000, 16'h0200, 5, 5, 5, 800, 1'b1);
      chk("restart_count", 64'(wr_cnt), 64'd15);

      // Abort in seg2, stray responses after release, then a clean run.
      lat = 3; ready_mode = 0;
      launch(32'h0004_0000, 32'h0005_0000, 32'h0006_0000, 16'h0300, 2, 2, 20);
      for (int n = 0; n < 300 && wr_cnt < 14; n++) step();
      chk("reached_seg2_w10", 64'(wr_cnt), 64'd14);
      rst_n = 1'b0;
      #1;
      exp_wr.delete(); exp_req.delete(); pend.delete();
      bench_outst = 0; prev_stall = 1'b0;
      chk("abort_req_valid", 64'(rd_req_valid), 64'd0);
      chk("abort_req_addr", 64'(rd_req_addr), 64'd0);
      chk("abort_wen", 64'(dma_wen), 64'd0);
      chk("abort_wa", 64'(dma_wa), 64'd0);
      chk("abort_wd", dma_wd, 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      chk("abort_seg_id", 64'(seg_id), 64'd3);
      repeat (2) step();
      rst_n = 1'b1;
      stray_left = 2;
      wr_cnt = 0;
      repeat (6) step();
      chk("no_write_after_reset", 64'(wr_cnt), 64'd0);
      run(32'h0007_0000, 32'h0008_0000, 32'h0009_0000, 16'h0400, 3, 1, 2, 300, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hwpe_dma_loader.md
Name: hwpe_dma_loader

Overview:
- Hardware load sequencer that replaces bench-driven DMA preloading of the hwpe SRAMs.
- Fetches 64-bit words from an external read port and drives the hwpe write port (dma_wen/dma_wa/dma_wd) in three segments, in fixed order:
  - seg0: fmap bank 1
  - seg1: fmap bank 2
  - seg2: kernel memory
- Sits between the system memory/bus adapter and hwpe; the MCU programs it and polls busy/done before issuing EAI compute instructions.

Parameters:
- ADDR_W, `HWPE_ADDR_WIDTH: hwpe write-address width (bytes)
- SRC_AW, 32: source byte-address width
- LEN_W, 16: segment length width, in 64-bit words
- MAX_OUTST, 4: max outstanding source reads (power of 2, 1..8)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; samples all cfg_* inputs
- cfg_src0/cfg_src1/cfg_src2  in  SRC_AW each  source byte base address per segment (8-byte aligned)
- cfg_dst0  in  ADDR_W  seg0 destination base
- cfg_len0/cfg_len1/cfg_len2  in  LEN_W each  words per segment; 0 = skip segment
- rd_req_valid  out  1  source read request
- rd_req_ready  in  1  source accepts request
- rd_req_addr  out  SRC_AW  source byte address
- rd_rsp_valid  in  1  read data valid; in-order; never back-pressured
- rd_rsp_data  in  64  read data
- dma_wen  out  1  hwpe write enable
- dma_wa  out  ADDR_W  hwpe byte write address
- dma_wd  out  64  hwpe write data
- busy  out  1  sequence in progress
- done  out  1  one-cycle pulse at completion
- seg_id  out  2  active segment for writes (0/1/2); 3 = idle

Behaviour:
- Reset values: rd_req_valid=0, rd_req_addr=0, dma_wen=0, dma_wa=0, dma_wd=0, busy=0, done=0, seg_id=3. All counters and the FSM clear asynchronously.
- Destination bases:
  - seg0: cfg_dst0
  - seg1: `FMEM_ADDR2_START
  - seg2: `KMEM_ADDR_START
- FSM states: IDLE, REQ, DRAIN, DONE.
  - IDLE: on start, latch the config, set busy on the next cycle, select the first nonzero segment, go to REQ. If all lengths are 0, go straight to DONE.
  - REQ: assert rd_req_valid while outstanding < MAX_OUTST and the segment request count < len.
    - On each rd_req_valid & rd_req_ready: rd_req_addr += 8.
    - When the last request of a segment is accepted, advance the request side to the next nonzero segment (rd_req_addr loads its src base).
    - After the last request of the last nonzero segment, go to DRAIN.
  - DRAIN: wait for outstanding==0 and the last write issued, then go to DONE.
  - DONE: pulse done for 1 cycle, clear busy, return to IDLE.
- Request/write pipeline:
  - rd_req_valid, once asserted, holds and keeps its address stable until accepted.
  - The outstanding counter increments on request accept and decrements on rd_rsp_valid. If both happen in the same cycle, it is unchanged.
  - Write side: a separate segment/word counter. Each rd_rsp_valid registers exactly one write the following cycle (dma_wen=1, dma_wa = dst base of the write segment + 8*word index, dma_wd = rd_rsp_data).
  - Latency: rsp to dma_wen = 1 cycle. dma_wen is deasserted otherwise.
  - seg_id tracks the write-side segment.
- Arithmetic: dma_wa wraps modulo 2^ADDR_W; rd_req_addr wraps modulo 2^SRC_AW. No overflow flag.
- Boundary and error handling:
  - start while busy: ignored.
  - rd_rsp_valid with outstanding==0: dropped, no write.
  - Segment switch with zero-length middle segment (e.g. len1=0): seg1 is skipped, no gap cycle required.
  - Segment boundaries on the request side and the write side are independent; requests for seg1 may be outstanding while seg0 writes finish.
- rst_n asserted mid-operation: immediate abort. Outputs return to reset values; late responses after release are dropped (outstanding==0).

Optional Feature:
- Macro HWPE_LOADER_CKSUM_EN.
- Defined:
  - Adds output cksum[63:0]: XOR of all dma_wd values written since the last start.
  - Cleared on start and on reset; updated in the same cycle dma_wen is high, visible one cycle later.
  - Stable after done.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared definitions in hwpe_define.vh:
  - loader FSM state encodings (IDLE=0, REQ=1, DRAIN=2, DONE=3)
  - SEG_IDLE=3
  - reuse of `FMEM_ADDR2_START, `KMEM_ADDR_START, `HWPE_ADDR_WIDTH
- One natural sub-module, hwpe_loader_seg_cnt: segment index + word counter with skip-zero-length advance. Instantiated twice, for the request side and the write side.

Test Plan:
- len0=len1=130, len2=1152, rd_req_ready=1, fixed 3-cycle response latency:
  - writes 130 words to cfg_dst0..+1032, then 130 to `FMEM_ADDR2_START.., then 1152 to `KMEM_ADDR_START..
  - done pulses exactly once; data matches source image; hwpe conv output matches golden.
- len0=3, len1=0, len2=2: writes dst0, dst0+8, dst0+16, then KMEM+0, KMEM+8; seg_id sequence 0,0,0,2,2; no bank-2 write.
- All lengths 0: done pulses 2 cycles after start, no rd_req_valid, no dma_wen.
- Random rd_req_ready (50%), MAX_OUTST=4: outstanding never exceeds 4; rd_req_addr stable while unaccepted; write count equals 2+3+4 for lens 2/3/4.
- Second start pulse while busy: ignored; total write count unchanged.
- rst_n low during seg2 word 10, then release with 2 stray responses: all outputs at reset values; no dma_wen after release; a new start completes normally.
